// File: rtl/echo_multi.sv
// echo_multi: multi-channel echo/delay effect.
//
// A frame that holds one sample per channel is accepted on each in_valid strobe. The
// channels are then handled one after another through their own circular delay lines.
// The output is dry + (delayed >>> MIX_SHIFT). When fb_en is set, the delay line stores
// dry + (delayed >>> FB_SHIFT) in place of the dry sample.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset; a reset starts a new CLEAR phase
//   in_valid   one-cycle strobe: data_in holds a new frame
//   data_in    frame; channel k = data_in[k*RESOLUTION +: RESOLUTION]
//   enable     1 = echo on, 0 = bypass (the delay line is still written)
//   fb_en      1 = feed the delayed sample back into the delay line
//   delay_len  echo delay in frames, clamped to 1..DEPTH
//   data_out   processed frame, packed the same way as data_in
//   out_valid  one-cycle strobe: data_out updated
//   busy       1 while clearing or processing; in_valid is ignored then
//   overrun    sticky until reset: in_valid arrived while busy
//
// Handshake: there is no backpressure. A frame is taken only when in_valid is high and
// busy is low. out_valid pulses for one cycle when the whole frame has been written to
// data_out. busy drops in that same cycle, so a new frame can be accepted right away.
module echo_multi #(
    parameter int RESOLUTION = 32,
    parameter int CHANNELS   = 2,
    parameter int DEPTH      = 128,
    parameter int MIX_SHIFT  = 1,
    parameter int FB_SHIFT   = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic [CHANNELS*RESOLUTION-1:0] data_in,
    input  logic                           enable,
    input  logic                           fb_en,
    input  logic [$clog2(DEPTH+1)-1:0]     delay_len,
    output logic [CHANNELS*RESOLUTION-1:0] data_out,
    output logic                           out_valid,
    output logic                           busy,
    output logic                           overrun
);

    localparam int AW  = $clog2(DEPTH);
    localparam int DLW = $clog2(DEPTH+1);
    localparam int PW  = DLW + 1;
    localparam int CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [RESOLUTION-1:0] SAT_MAX = {1'b0, {(RESOLUTION-1){1'b1}}};
    localparam logic [RESOLUTION-1:0] SAT_MIN = {1'b1, {(RESOLUTION-1){1'b0}}};

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_RD,
        S_CALC,
        S_DONE
    } state_t;

    state_t                         state;
    logic [AW-1:0]                  clr_addr;
    logic [AW-1:0]                  wr_ptr;
    logic [CW-1:0]                  ch;
    logic [CHANNELS*RESOLUTION-1:0] frame_q;
    logic                           en_q;
    logic                           fb_q;
    logic [DLW-1:0]                 dl_q;
    logic signed [RESOLUTION-1:0]   d_q;

    // One delay line per channel. Every line shares the same write and read pointers.
    logic [RESOLUTION-1:0] mem [CHANNELS][DEPTH];

    // Add two values at RESOLUTION+1 bits, then clamp the result to the signed range.
    function automatic logic [RESOLUTION-1:0] sat_add(
        input logic [RESOLUTION-1:0] a,
        input logic [RESOLUTION-1:0] b
    );
        logic [RESOLUTION:0] s;
        s = {a[RESOLUTION-1], a} + {b[RESOLUTION-1], b};
        if (s[RESOLUTION] != s[RESOLUTION-1])
            return s[RESOLUTION] ? SAT_MIN : SAT_MAX;
        return s[RESOLUTION-1:0];
    endfunction

    // The clamped delay is latched at accept. A delay_len change therefore waits for the next frame.
    logic [DLW-1:0] dl_clamped;
    always_comb begin
        dl_clamped = delay_len;
        if (delay_len == '0)
            dl_clamped = DLW'(1);
        else if (int'(delay_len) > DEPTH)
            dl_clamped = DLW'(DEPTH);
    end

    // rd_ptr = (wr_ptr - dl) mod DEPTH. Adding DEPTH first keeps the value non-negative.
    logic [PW-1:0] rd_sum;
    logic [AW-1:0] rd_ptr;
    always_comb begin
        rd_sum = PW'(wr_ptr) + PW'(DEPTH) - PW'(dl_q);
        if (rd_sum >= PW'(DEPTH))
            rd_sum = rd_sum - PW'(DEPTH);
        rd_ptr = rd_sum[AW-1:0];
    end

    logic signed [RESOLUTION-1:0] x;
    logic signed [RESOLUTION-1:0] d_mix;
    logic signed [RESOLUTION-1:0] d_fb;
    logic [RESOLUTION-1:0]        y_val;
    logic [RESOLUTION-1:0]        w_val;
    always_comb begin
        x     = frame_q[ch*RESOLUTION +: RESOLUTION];
        d_mix = d_q >>> MIX_SHIFT;
        d_fb  = d_q >>> FB_SHIFT;
        y_val = en_q ? sat_add(x, d_mix) : x;
        w_val = fb_q ? sat_add(x, d_fb) : x;
    end

    // The delay memory has no reset. The CLEAR phase zeroes it one address per cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == S_CLEAR) begin
                for (int k = 0; k < CHANNELS; k++)
                    mem[k][clr_addr] <= '0;
            end else if (state == S_CALC) begin
                mem[ch][wr_ptr] <= w_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_CLEAR;
            clr_addr  <= '0;
            wr_ptr    <= '0;
            ch        <= '0;
            frame_q   <= '0;
            en_q      <= 1'b0;
            fb_q      <= 1'b0;
            dl_q      <= DLW'(1);
            d_q       <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b1;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid && busy)
                overrun <= 1'b1;

            case (state)
                S_CLEAR: begin
                    if (clr_addr == AW'(DEPTH-1)) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end

                // DONE also accepts a frame. This allows back-to-back frames at the minimum spacing.
                S_IDLE, S_DONE: begin
                    if (state == S_DONE)
                        wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
                    if (in_valid) begin
                        frame_q <= data_in;
                        en_q    <= enable;
                        fb_q    <= fb_en;
                        dl_q    <= dl_clamped;
                        ch      <= '0;
                        busy    <= 1'b1;
                        state   <= S_RD;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                S_RD: begin
                    d_q   <= mem[ch][rd_ptr];
                    state <= S_CALC;
                end

                S_CALC: begin
                    data_out[ch*RESOLUTION +: RESOLUTION] <= y_val;
                    if (ch == CW'(CHANNELS-1)) begin
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_DONE;
                    end else begin
                        ch    <= ch + 1'b1;
                        state <= S_RD;
                    end
                end

                default: state <= S_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_echo_multi.sv
// tb_echo_multi: directed, table-driven bench for echo_multi with default parameters
// (RESOLUTION=32, CHANNELS=2, DEPTH=128, MIX_SHIFT=1, FB_SHIFT=2).
// Each table row holds one frame, the expected output for both channels, and an optional
// reset to apply before that frame. Hand-written sequences cover overrun, wrap-around and
// a reset arriving mid-frame.
module tb_echo_multi;

    localparam int R   = 32;
    localparam int C   = 2;
    localparam int D   = 128;
    localparam int DLW = $clog2(D+1);
    localparam int LAT = 2*C + 1;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic [C*R-1:0] data_in;
    logic           enable;
    logic           fb_en;
    logic [DLW-1:0] delay_len;
    logic [C*R-1:0] data_out;
    logic           out_valid;
    logic           busy;
    logic           overrun;

    int n_tests = 0;
    int n_fail  = 0;

    echo_multi #(
        .RESOLUTION(R), .CHANNELS(C), .DEPTH(D), .MIX_SHIFT(1), .FB_SHIFT(2)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .data_in(data_in),
        .enable(enable), .fb_en(fb_en), .delay_len(delay_len),
        .data_out(data_out), .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           rst;
        logic [R-1:0]   c0;
        logic [R-1:0]   c1;
        logic           en;
        logic           fb;
        logic [DLW-1:0] dl;
        logic [R-1:0]   e0;
        logic [R-1:0]   e1;
        string          name;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic [R-1:0] c0, input logic [R-1:0] c1,
                                input logic en, input logic fb, input logic [DLW-1:0] dl,
                                input logic [R-1:0] e0, input logic [R-1:0] e1, input string name);
        vec_t v;
        v.rst = rst; v.c0 = c0; v.c1 = c1; v.en = en; v.fb = fb; v.dl = dl;
        v.e0 = e0; v.e1 = e1; v.name = name;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Hold reset for two cycles and check the reset values. Then count the cycles in which
    // busy stays high during the CLEAR phase.
    task automatic do_reset();
        int cnt;
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_data_out", data_out, '0);
        check("rst_out_valid", out_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 1);
        reset = 1'b0;
        cnt   = 0;
        while (busy && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        check("clear_cycles", cnt, D);
    endtask

    // Drive one frame for a single cycle, then wait (bounded) for out_valid.
    task automatic send(input logic [R-1:0] c0, input logic [R-1:0] c1, input logic en,
                        input logic fb, input logic [DLW-1:0] dl,
                        output logic [C*R-1:0] out, output int lat);
        @(negedge clk);
        data_in   = {c1, c0};
        enable    = en;
        fb_en     = fb;
        delay_len = dl;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        out = data_out;
    endtask

    logic [C*R-1:0] out;
    int             lat;
    int             cnt;
    int             ov_cnt;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        data_in   = '0;
        enable    = 1'b1;
        fb_en     = 1'b0;
        delay_len = DLW'(1);

        // After reset the memory is cleared, so a zero frame yields zero output.
        add(1, 0, 0, 1, 0, 4, 0, 0, "zero_after_clear");

        // Impulse with delay 4 and no feedback. The echo appears once, at half amplitude.
        for (int f = 0; f < 10; f++)
            add(f == 0, (f == 0) ? 32'h4000_0000 : 32'h0, 0, 1, 0, 4,
                (f == 0) ? 32'h4000_0000 : (f == 4) ? 32'h2000_0000 : 32'h0, 0, "impulse");

        // With feedback, each echo is (previous write >>> 2) >>> 1.
        for (int f = 0; f < 14; f++)
            add(f == 0, (f == 0) ? 32'h4000_0000 : 32'h0, 0, 1, 1, 4,
                (f == 0)  ? 32'h4000_0000 : (f == 4) ? 32'h2000_0000 :
                (f == 8)  ? 32'h0800_0000 : (f == 12) ? 32'h0200_0000 : 32'h0,
                0, "feedback");

        // Saturation, arithmetic shift, bypass and delay clamping, all with delay 1.
        add(1, 32'h7FFF_FFFF, 32'h8000_0000, 1, 0, 1, 32'h7FFF_FFFF, 32'h8000_0000, "sat_first");
        add(0, 32'h7FFF_FFFF, 32'h8000_0000, 1, 0, 1, 32'h7FFF_FFFF, 32'h8000_0000, "sat_clamp");
        add(0, 32'h1111_1111, 32'h2222_2222, 0, 0, 1, 32'h1111_1111, 32'h2222_2222, "bypass");
        add(0, 0, 0, 1, 0, 1, 32'h0888_8888, 32'h1111_1111, "bypass_wrote_mem");
        add(0, 0, 32'h8000_0000, 1, 0, 1, 0, 32'h8000_0000, "neg_in");
        add(0, 0, 0, 1, 0, 1, 0, 32'hC000_0000, "neg_shift");
        add(0, 32'h1000_0000, 0, 1, 0, 0, 32'h1000_0000, 0, "dl0_first");
        add(0, 32'h2000_0000, 0, 1, 0, 0, 32'h2800_0000, 0, "dl0_as_1");
        add(0, 0, 0, 1, 0, DLW'(D+1), 0, 0, "dl_over_depth");

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst)
                do_reset();
            send(vecs[i].c0, vecs[i].c1, vecs[i].en, vecs[i].fb, vecs[i].dl, out, lat);
            check({vecs[i].name, "_ch0"}, out[R-1:0], vecs[i].e0);
            check({vecs[i].name, "_ch1"}, out[2*R-1:R], vecs[i].e1);
            check({vecs[i].name, "_latency"}, lat, LAT);
        end

        // Overrun: a second strobe two cycles after accept is dropped and sets the sticky flag.
        do_reset();
        @(negedge clk);
        data_in   = {32'h0200_0000, 32'h0100_0000};
        enable    = 1'b1;
        fb_en     = 1'b0;
        delay_len = DLW'(4);
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        data_in  = {32'h7000_0000, 32'h7000_0000};
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        ov_cnt   = 0;
        for (int k = 0; k < 20; k++) begin
            if (out_valid)
                ov_cnt++;
            @(negedge clk);
        end
        check("overrun_one_out_valid", ov_cnt, 1);
        check("overrun_flag", overrun, 1);
        check("overrun_frame_kept", data_out, {32'h0200_0000, 32'h0100_0000});
        send(32'h5, 32'h6, 1, 0, 4, out, lat);
        check("overrun_sticky", overrun, 1);
        check("overrun_next_frame", out, {32'h6, 32'h5});

        // Wrap: with delay DEPTH, the ch1 impulse returns exactly DEPTH frames later.
        do_reset();
        for (int f = 0; f < 2*D; f++) begin
            send(0, (f == 0) ? 32'h4000_0000 : 32'h0, 1, 0, DLW'(D), out, lat);
            check("wrap_ch1", out[2*R-1:R],
                  (f == 0) ? 32'h4000_0000 : (f == D) ? 32'h2000_0000 : 32'h0);
            if (f == 0 || f == D)
                check("wrap_ch0", out[R-1:0], 0);
        end

        // Mid-frame reset: write a nonzero sample at address 0, then reset during RD.
        do_reset();
        send(32'h4000_0000, 32'h4000_0000, 1, 0, 1, out, lat);
        check("pre_reset_frame", out, {32'h4000_0000, 32'h4000_0000});
        @(negedge clk);
        data_in  = {32'h1234_5678, 32'h1234_5678};
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        check("midrst_data_out", data_out, '0);
        check("midrst_busy", busy, 1);
        reset  = 1'b0;
        cnt    = 0;
        ov_cnt = 0;
        while (busy && cnt < 1000) begin
            if (out_valid)
                ov_cnt++;
            cnt++;
            @(negedge clk);
        end
        check("midrst_no_out_valid", ov_cnt, 0);
        check("midrst_clear_cycles", cnt, D);
        // With delay DEPTH and wr_ptr=0, the read hits address 0, which CLEAR must have zeroed.
        send(0, 0, 1, 0, DLW'(D), out, lat);
        check("midrst_mem_cleared", out, '0);
        check("midrst_latency", lat, LAT);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
